msg_receiver: RTL

- Serial frame receiver for the single-bit message line `msg_bit` driven by the message transmit stage.
- Frame format, one bit per BIT_CYCLES clocks, MSB first: preamble 0,1,0,1, then 5 message bits. The line idles at 0.
- Aligns to the first preamble rising edge, samples each following bit at mid-period, checks the preamble and presents the 5-bit message with a one-cycle valid strobe.
- Sits directly downstream of the transmitter, on the same clock, for loopback and decode.

---
 rtl/msg_receiver_if.sv | 25 ++
 rtl/msg_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/msg_receiver_if.sv
// msg_receiver_if: serial line into the receiver plus its decoded outputs.
// master drives rx_bit and observes; slave is the receiver side.
interface msg_receiver_if;
  logic       rx_bit;
  logic [4:0] msg_out;
  logic       msg_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_bit,
    input  msg_out,
    input  msg_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx_bit,
    output msg_out,
    output msg_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/msg_receiver.sv
// msg_receiver: aligns to the first preamble rising edge of rx_bit, samples
// each later bit mid-period, checks preamble 0,1 and strobes a 5-bit message.
// Ports: clk, rst (async, active high), bus (slave): rx_bit in;
//   msg_out[4:0], msg_valid, frame_err, busy out.
// Option: define MSG_RX_MAJORITY_EN for 2-of-3 voting around mid-period.
module msg_receiver #(
  parameter int BIT_CYCLES = 1024,
  parameter int CW = $clog2(BIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  msg_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    GUARD
  } state_t;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(BIT_CYCLES / 2 - 1);
`ifdef MSG_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_V0   = CW'(BIT_CYCLES / 2 - 2);
  localparam logic [CW-1:0] CNT_SH   = CW'(BIT_CYCLES / 2);
`else
  localparam logic [CW-1:0] CNT_SH   = CNT_MID;
`endif

  logic          s1_q, s2_q, s3_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  // First six captured bits; the seventh is the live sample at completion.
  logic [5:0]    sh_q, sh_d;
  logic [4:0]    msg_q, msg_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          rise;
  logic          bit_val;
  logic          shift_en;
  logic [6:0]    cap;
`ifdef MSG_RX_MAJORITY_EN
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.rx_bit;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

`ifdef MSG_RX_MAJORITY_EN
  assign bit_val = (v0_q & v1_q) | (v0_q & s2_q) | (v1_q & s2_q);
`else
  assign bit_val = s2_q;
`endif

  assign shift_en = (state_q == RECV) && (cnt_q == CNT_SH) &&
                    (idx_q >= 4'd2);
  assign cap = {sh_q, bit_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      msg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MSG_RX_MAJORITY_EN
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      msg_q   <= msg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef MSG_RX_MAJORITY_EN
      v0_q    <= v0_d;
      v1_q    <= v1_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    msg_d   = msg_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef MSG_RX_MAJORITY_EN
    v0_d    = v0_q;
    v1_d    = v1_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // The edge cycle itself is count 0 of bit 1, so the next is 1.
        if (rise) begin
          cnt_d   = CNT_ONE;
          idx_d   = 4'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`ifdef MSG_RX_MAJORITY_EN
        if (cnt_q == CNT_V0)  v0_d = s2_q;
        if (cnt_q == CNT_MID) v1_d = s2_q;
`endif
        if (shift_en) begin
          sh_d = cap[5:0];
          // Decide on entry so the registered strobe spans the CHECK cycle.
          if (idx_q == 4'd8) begin
            state_d = CHECK;
            if (cap[6:5] == 2'b01) begin
              msg_d   = cap[4:0];
              valid_d = 1'b1;
            end else begin
              err_d   = 1'b1;
            end
          end
        end
      end
      CHECK: begin
        state_d = GUARD;
      end
      GUARD: begin
        if (!s2_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.msg_out   = msg_q;
  assign bus.msg_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
